bitstream_tx: RTL and testbench

- Transmit end of the serial random-bit interface consumed by the on-chip statistical health tests (monobit, runs and related tests).
- Accepts parallel PUF/TRNG response words over a valid/ready handshake and emits one bit per clock, MSB first.
- Marks N-bit test-block boundaries so that downstream testers align their counting windows to the stream.
- Sits between the PUF response collector and the health-test bank.

---
 rtl/puf_pkg.sv | 15 +
 rtl/bitstream_tx_if.sv | 34 +++
 rtl/block_framer.sv | 41 ++++
 rtl/bitstream_tx.sv | 127 ++++++++++++
 tb/tb_bitstream_tx.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared PUF random-stream constants and transmitter state encoding.
// Health tests import the same block length and counter width.
package puf_pkg;

  localparam int PUF_W  = 32;
  localparam int PUF_N  = 20000;
  localparam int PUF_CW = 15;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIFT = 2'd1,
    PAUSE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/bitstream_tx_if.sv
// Word handshake in, framed serial bit stream out.
// master drives words, slave is the transmitter.
interface bitstream_tx_if
  import puf_pkg::*;
#(
  parameter int W  = PUF_W,
  parameter int CW = PUF_CW
);

  logic [W-1:0]  word_in;
  logic          word_valid;
  logic          word_ready;
  logic          rand_bit;
  logic          bit_valid;
  logic          block_start;
  logic          block_end;
  logic [CW-1:0] bit_count;
  logic          underrun;

  modport master (
    output word_in, word_valid,
    input  word_ready, rand_bit, bit_valid,
    input  block_start, block_end,
    input  bit_count, underrun
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, rand_bit, bit_valid,
    output block_start, block_end,
    output bit_count, underrun
  );

endinterface

// File: rtl/block_framer.sv
// Block position counter driven by a bit-emit strobe.
// Outputs line up with the registered bit they describe.
module block_framer
  import puf_pkg::*;
#(
  parameter int N  = PUF_N,
  parameter int CW = PUF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          emit,
  output logic [CW-1:0] bit_count,
  output logic          block_start,
  output logic          block_end
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] idx;
  logic [CW-1:0] idx_nxt;

  assign idx_nxt = (idx == LAST) ? '0 : idx + CW'(1);

  // idx is the index the next emitted bit will carry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      bit_count   <= '0;
      block_start <= 1'b0;
      block_end   <= 1'b0;
    end else begin
      block_start <= emit & (idx == '0);
      block_end   <= emit & (idx == LAST);
      if (emit) begin
        bit_count <= idx;
        idx       <= idx_nxt;
      end
    end
  end

endmodule

// File: rtl/bitstream_tx.sv
// Parallel word to MSB-first serial bit stream with block framing.
// SR shifts out, HR holds one word so refill is gap-free.
module bitstream_tx
  import puf_pkg::*;
#(
  parameter int W  = PUF_W,
  parameter int N  = PUF_N,
  parameter int CW = PUF_CW
) (
  input logic           clk,
  input logic           rst,
  input logic           en,
  bitstream_tx_if.slave bus
);

  localparam int KW = $clog2(W + 1);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [W-1:0]  sr;
  logic [W-1:0]  hr;
  logic [KW-1:0] cnt;
  logic          hr_full;
  logic          emit;
  logic          last;
  logic          slot;
  logic          ready;
  logic          take;
  logic          ld_hr;
  logic          ld_in;
  logic          rand_q;
  logic          valid_q;
  logic          und_q;
  logic [CW-1:0] cnt_q;
  logic          start_q;
  logic          end_q;

  assign emit  = en & (state != EMPTY);
  assign last  = emit & (cnt == KW'(1));
  // SR can take a word when empty or when its last bit leaves now
  assign slot  = (state == EMPTY) | last;
  assign ready = ~hr_full | slot;
  assign take  = bus.word_valid & ready;
  assign ld_hr = hr_full & slot;
  assign ld_in = take & ~hr_full & slot;

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (hr_full | take)
          state_nxt = SHIFT;
      end
      SHIFT, PAUSE: begin
        if (!en)
          state_nxt = PAUSE;
        else if (last & ~hr_full & ~take)
          state_nxt = EMPTY;
        else
          state_nxt = SHIFT;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      hr      <= '0;
      cnt     <= '0;
      hr_full <= 1'b0;
      rand_q  <= 1'b0;
      valid_q <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      if (ld_hr) begin
        sr  <= hr;
        cnt <= KW'(W);
      end else if (ld_in) begin
        sr  <= bus.word_in;
        cnt <= KW'(W);
      end else if (emit) begin
        sr  <= sr << 1;
        cnt <= cnt - 1'b1;
      end
      if (take & ~ld_in)
        hr <= bus.word_in;
      if (ld_hr)
        hr_full <= take;
      else if (take & ~ld_in)
        hr_full <= 1'b1;
      if (emit)
        rand_q <= sr[W-1];
      valid_q <= emit;
      if (en & valid_q & ~emit)
        und_q <= 1'b1;
    end
  end

  block_framer #(
    .N  (N),
    .CW (CW)
  ) u_framer (
    .clk         (clk),
    .rst         (rst),
    .emit        (emit),
    .bit_count   (cnt_q),
    .block_start (start_q),
    .block_end   (end_q)
  );

  assign bus.word_ready  = ready;
  assign bus.rand_bit    = rand_q;
  assign bus.bit_valid   = valid_q;
  assign bus.underrun    = und_q;
  assign bus.bit_count   = cnt_q;
  assign bus.block_start = start_q;
  assign bus.block_end   = end_q;

endmodule

// File: tb/tb_bitstream_tx.sv
// Bench for bitstream_tx: W=32/N=20000 and W=8/N=20 instances
// checked every cycle against a word-queue stream model.
module tb_bitstream_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en[2]  = '{1'b0, 1'b0};
  logic        vld[2] = '{1'b0, 1'b0};
  logic [31:0] wd[2]  = '{32'd0, 32'd0};

  bitstream_tx_if #(.W(32), .CW(15)) ifa ();
  bitstream_tx_if #(.W(8),  .CW(5))  ifb ();

  assign ifa.word_in    = wd[0];
  assign ifa.word_valid = vld[0];
  assign ifb.word_in    = wd[1][7:0];
  assign ifb.word_valid = vld[1];

  bitstream_tx #(.W(32), .N(20000), .CW(15)) dut_a (
    .clk (clk), .rst (rst), .en (en[0]), .bus (ifa)
  );
  bitstream_tx #(.W(8), .N(20), .CW(5)) dut_b (
    .clk (clk), .rst (rst), .en (en[1]), .bus (ifb)
  );

  logic o_bit[2], o_val[2], o_st[2], o_end[2], o_und[2], o_rdy[2];
  int   o_cnt[2];
  assign o_bit[0] = ifa.rand_bit;    assign o_bit[1] = ifb.rand_bit;
  assign o_val[0] = ifa.bit_valid;   assign o_val[1] = ifb.bit_valid;
  assign o_st[0]  = ifa.block_start; assign o_st[1]  = ifb.block_start;
  assign o_end[0] = ifa.block_end;   assign o_end[1] = ifb.block_end;
  assign o_und[0] = ifa.underrun;    assign o_und[1] = ifb.underrun;
  assign o_rdy[0] = ifa.word_ready;  assign o_rdy[1] = ifb.word_ready;
  assign o_cnt[0] = int'(ifa.bit_count);
  assign o_cnt[1] = int'(ifb.bit_count);

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: the block holds at most two words; bits leave MSB first
  int          wm[2] = '{32, 8};
  int          nm[2] = '{20000, 20};
  logic [31:0] held[2][2];
  int          nw[2]  = '{0, 0};
  int          rem[2] = '{0, 0};
  int          idx[2] = '{0, 0};
  logic        e_bit[2] = '{1'b0, 1'b0};
  logic        e_val[2] = '{1'b0, 1'b0};
  logic        e_st[2]  = '{1'b0, 1'b0};
  logic        e_end[2] = '{1'b0, 1'b0};
  logic        e_und[2] = '{1'b0, 1'b0};
  int          e_cnt[2] = '{0, 0};

  function automatic logic ready_m(input int i);
    return (nw[i] < 2) || (en[i] && rem[i] == 1);
  endfunction

  function automatic logic [31:0] mask(input int i);
    return (wm[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << wm[i]) - 32'd1);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    for (int i = 0; i < 2; i++) begin
      logic r;
      if (!rst) begin
        nw[i] = 0; rem[i] = 0; idx[i] = 0; e_cnt[i] = 0;
        e_val[i] = 0; e_st[i] = 0; e_end[i] = 0; e_und[i] = 0;
      end else begin
        r = ready_m(i);
        if (en[i] && nw[i] > 0) begin
          e_bit[i] = held[i][0][rem[i]-1];
          e_val[i] = 1'b1;
          e_cnt[i] = idx[i];
          e_st[i]  = (idx[i] == 0);
          e_end[i] = (idx[i] == nm[i] - 1);
          idx[i]   = (idx[i] == nm[i] - 1) ? 0 : idx[i] + 1;
          rem[i]--;
          if (rem[i] == 0) begin
            held[i][0] = held[i][1];
            nw[i]--;
            rem[i] = (nw[i] > 0) ? wm[i] : 0;
          end
        end else begin
          if (en[i] && e_val[i]) e_und[i] = 1'b1;
          e_val[i] = 1'b0; e_st[i] = 1'b0; e_end[i] = 1'b0;
        end
        if (vld[i] && r) begin
          held[i][nw[i]] = wd[i] & mask(i);
          nw[i]++;
          if (nw[i] == 1) rem[i] = wm[i];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), o_val[i], e_val[i]);
      chk($sformatf("start%0d", i), o_st[i], e_st[i]);
      chk($sformatf("end%0d", i), o_end[i], e_end[i]);
      chk($sformatf("underrun%0d", i), o_und[i], e_und[i]);
      chk($sformatf("ready%0d", i), o_rdy[i], ready_m(i));
      if (e_val[i]) begin
        chk($sformatf("rand%0d", i), o_bit[i], e_bit[i]);
        chk($sformatf("count%0d", i), o_cnt[i], e_cnt[i]);
      end
    end
  end

  // Word feeder: offers words until acc reaches target
  int          acc[2]    = '{0, 0};
  int          target[2] = '{0, 0};
  logic        pmode[2]  = '{1'b0, 1'b0};
  logic [31:0] pbase[2]  = '{32'd0, 32'd0};

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (rst && vld[i] && o_rdy[i]) acc[i]++;
    #1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = (acc[i] < target[i]);
      wd[i]  = pbase[i] ^ (pmode[i] ? acc[i] * 32'h0100_0193 : 32'd0);
    end
  end

  // Stream observer for hand-computed checks
  int       vcount[2] = '{0, 0};
  int       nst[2]    = '{0, 0};
  int       starts[2][4];
  logic [7:0] first8[2] = '{8'd0, 8'd0};

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        vcount[i] = 0; nst[i] = 0; first8[i] = 8'd0;
      end else if (o_val[i]) begin
        if (o_st[i]) begin
          if (nst[i] < 4) starts[i][nst[i]] = vcount[i];
          nst[i]++;
        end
        if (vcount[i] < 8) first8[i] = {first8[i][6:0], o_bit[i]};
        vcount[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      target[i] = acc[i];
      en[i] = 1'b0;
    end
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic feed(input int i, input logic m, input logic [31:0] b,
                      input int n);
    pmode[i] = m; pbase[i] = b; target[i] = acc[i] + n;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int a0;

    do_reset();
    chk("rst_ready", o_rdy[0], 1);
    en[0] = 1'b1;
    feed(0, 1'b0, 32'hA5A5_A5A5, 1);
    repeat (40) tick();
    chk("t1_first8", first8[0], 8'hA5);
    chk("t1_bits", vcount[0], 32);
    chk("t1_nstart", nst[0], 1);
    chk("t1_start_pos", starts[0][0], 0);
    chk("t1_valid_low", o_val[0], 0);
    chk("t1_underrun", o_und[0], 1);

    do_reset();
    en[0] = 1'b1;
    feed(0, 1'b0, 32'hA5A5_A5A5, 1);
    for (k = 0; k < 50; k++) begin
      tick();
      if (o_val[0] && o_cnt[0] == 10) break;
    end
    chk("t4_wait_timeout", k >= 50, 0);
    en[0] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t4_pause_valid", o_val[0], 0);
      chk("t4_pause_count", o_cnt[0], 10);
    end
    en[0] = 1'b1;
    tick();
    chk("t4_resume_valid", o_val[0], 1);
    chk("t4_resume_count", o_cnt[0], 11);
    chk("t4_resume_bit", o_bit[0], 0);
    chk("t4_no_underrun", o_und[0], 0);
    repeat (30) tick();

    do_reset();
    a0 = acc[0];
    feed(0, 1'b1, 32'h1357_9BDF, 1000);
    repeat (6) tick();
    chk("t3_accepted", acc[0] - a0, 2);
    chk("t3_ready_low", o_rdy[0], 0);
    en[0] = 1'b1;
    repeat (60) tick();
    en[0] = 1'b0;
    repeat (8) tick();
    en[0] = 1'b1;
    repeat (40) tick();
    target[0] = acc[0];
    repeat (80) tick();
    chk("t3_total_bits", vcount[0], 32 * (acc[0] - a0));

    do_reset();
    en[0] = 1'b1;
    feed(0, 1'b0, 32'hFFFF_FFFF, 626);
    for (k = 0; k < 21000; k++) begin
      tick();
      if (o_end[0]) break;
    end
    chk("t2_end_timeout", k >= 21000, 0);
    chk("t2_end_count", o_cnt[0], 19999);
    chk("t2_end_underrun", o_und[0], 0);
    chk("t2_bits_before", vcount[0], 19999);
    tick();
    chk("t2_next_start", o_st[0], 1);
    chk("t2_next_count", o_cnt[0], 0);
    chk("t2_next_bit", o_bit[0], 1);
    chk("t2_next_underrun", o_und[0], 0);
    target[0] = acc[0];
    repeat (60) tick();

    do_reset();
    en[0] = 1'b1;
    feed(0, 1'b1, 32'h3C3C_5AA5, 1000);
    for (k = 0; k < 7300; k++) begin
      tick();
      if (o_val[0] && o_cnt[0] == 7000) break;
    end
    chk("t5_wait_timeout", k >= 7300, 0);
    target[0] = acc[0];
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_rand", o_bit[0], 0);
    chk("t5_rst_valid", o_val[0], 0);
    chk("t5_rst_start", o_st[0], 0);
    chk("t5_rst_end", o_end[0], 0);
    chk("t5_rst_count", o_cnt[0], 0);
    chk("t5_rst_underrun", o_und[0], 0);
    chk("t5_rst_ready", o_rdy[0], 1);
    tick(); tick();
    rst = 1'b1;
    feed(0, 1'b0, 32'h8000_0001, 1);
    for (k = 0; k < 10; k++) begin
      tick();
      if (o_val[0]) break;
    end
    chk("t5_restart_timeout", k >= 10, 0);
    chk("t5_restart_count", o_cnt[0], 0);
    chk("t5_restart_start", o_st[0], 1);
    chk("t5_restart_bit", o_bit[0], 1);
    repeat (40) tick();

    do_reset();
    en[1] = 1'b1;
    feed(1, 1'b1, 32'h0000_005B, 12);
    repeat (110) tick();
    chk("t6_bits", vcount[1], 96);
    chk("t6_nstart", nst[1], 5);
    chk("t6_start0", starts[1][0], 0);
    chk("t6_start1", starts[1][1], 20);
    chk("t6_start2", starts[1][2], 40);
    chk("t6_start3", starts[1][3], 60);
    chk("t6_underrun", o_und[1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
